ram_seq_ctrl: RTL

- Parametrised, clocked successor to the GPU command-decoded RAM enable logic.
- Accepts one opcode per handshake and sequences multi-word RAM accesses: burst write from a data stream, burst read with fixed-latency return, full-RAM clear.
- Sits between the GPU command decoder and the single-port frame/sprite RAM; owns all RAM address, enable and write-data pins.

---
 rtl/ram_seq_if.sv | 38 +++
 rtl/ram_seq_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ram_seq_if.sv
// Signal bundle between the GPU command decoder, the RAM sequencer and the frame/sprite RAM.
// The controller takes the slave view; the decoder/RAM side takes the master view.
interface ram_seq_if #(
    parameter int CMD_W  = 5,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  command;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  cmd_valid, command, cmd_addr, cmd_len, wr_valid, wr_data, ram_rdata,
        output cmd_ready, wr_ready, ram_addr, ram_wdata, ram_we, ram_re,
               rd_valid, rd_data, busy, done, err
    );

    modport master (
        output cmd_valid, command, cmd_addr, cmd_len, wr_valid, wr_data, ram_rdata,
        input  cmd_ready, wr_ready, ram_addr, ram_wdata, ram_we, ram_re,
               rd_valid, rd_data, busy, done, err
    );
endinterface

// File: rtl/ram_seq_ctrl.sv
// Single-port RAM sequencer: one opcode per handshake, runs burst write, burst read
// with fixed-latency return, or a full clear, and owns every RAM address/enable/data pin.
module ram_seq_ctrl #(
    parameter int                 CMD_W     = 5,
    parameter int                 ADDR_W    = 16,
    parameter int                 DATA_W    = 16,
    parameter int unsigned        DEPTH     = 65536,
    parameter int                 RD_LAT    = 1,
    parameter logic [DATA_W-1:0]  CLR_VAL   = '0,
    parameter logic [CMD_W-1:0]   OPC_WRITE = 5'b10010,
    parameter logic [CMD_W-1:0]   OPC_READ  = 5'b01010,
    parameter logic [CMD_W-1:0]   OPC_CLR_A = 5'b11000,
    parameter logic [CMD_W-1:0]   OPC_CLR_B = 5'b11010
) (
    input  logic     clk,
    input  logic     rst,
    ram_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, CLEAR, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_re_q, ram_re_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cmd_ready_q, busy_q;
    logic [RD_LAT-1:0] vld_q, vld_nxt;
    logic              accept;
    logic              rd_valid;

    assign accept   = bus.cmd_valid && cmd_ready_q;
    assign rd_valid = vld_q[RD_LAT-1];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        // Issued-read tracker: one bit per outstanding RAM read latency stage.
        vld_nxt     = '0;
        vld_nxt[0]  = ram_re_q;
        for (int i = 1; i < RD_LAT; i++) vld_nxt[i] = vld_q[i-1];

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = bus.cmd_addr;
                    cnt_d  = bus.cmd_len;
                    if (bus.command == OPC_WRITE) begin
                        state_d = WRITE;
                    end else if (bus.command == OPC_READ) begin
                        state_d = READ;
                    end else if (bus.command == OPC_CLR_A || bus.command == OPC_CLR_B) begin
                        state_d = CLEAR;
                        addr_d  = '0;
                        cnt_d   = ADDR_W'(DEPTH - 1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = addr_q;
                    ram_wdata_d = bus.wr_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q - ADDR_W'(1);
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                ram_re_d   = 1'b1;
                ram_addr_d = addr_q;
                addr_d     = addr_q + ADDR_W'(1);
                cnt_d      = cnt_q - ADDR_W'(1);
                if (cnt_q == '0) state_d = DRAIN;
            end
            CLEAR: begin
                ram_we_d    = 1'b1;
                ram_addr_d  = addr_q;
                ram_wdata_d = CLR_VAL;
                addr_d      = addr_q + ADDR_W'(1);
                cnt_d       = cnt_q - ADDR_W'(1);
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                // Finish once the final return word is leaving the pipe this cycle.
                if (vld_nxt == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            vld_q       <= vld_nxt;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.wr_ready  = (state_q == WRITE);
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.rd_valid  = rd_valid;
    assign bus.rd_data   = rd_valid ? bus.ram_rdata : '0;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
